// File: rtl/mem_bus_sched_if.sv
// Bus-side bundle for mem_bus_sched: per-requester request/direction in, grant and bus
// controls out. The scheduler connects through the slave modport.
interface mem_bus_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ-1:0] i_rw;
  logic [NUM_REQ-1:0] o_grant;
  logic               o_data_bus_enable;
  logic               o_data_bus_rw;
  logic               o_busy;
  logic               o_preempt;

  modport master (
    output i_req,
    output i_rw,
    input  o_grant,
    input  o_data_bus_enable,
    input  o_data_bus_rw,
    input  o_busy,
    input  o_preempt
  );

  modport slave (
    input  i_req,
    input  i_rw,
    output o_grant,
    output o_data_bus_enable,
    output o_data_bus_rw,
    output o_busy,
    output o_preempt
  );
endinterface

// File: rtl/mem_bus_sched.sv
// Round-robin owner scheduler for the external memory data bus with a fixed turnaround gap.
// Optional hold-limit preemption is enabled by defining MBS_HOLD_LIMIT_EN.
module mem_bus_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TURNAROUND = 3,
  parameter int unsigned MAX_GRANT  = 16
) (
  input  logic            clk_166M66,
  input  logic            mcu_sys_rst,
  mem_bus_sched_if.slave  io_bus
);
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TURNAROUND > 15 || MAX_GRANT < 2 || MAX_GRANT > 255)
  begin : g_bad_params
    $error("mem_bus_sched: parameter out of legal range");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e             r_state, w_state_nxt;
  logic [PtrW-1:0]    r_ptr, w_ptr_nxt;
  logic [PtrW-1:0]    r_owner, w_owner_nxt;
  logic [PtrW-1:0]    w_winner, w_idx;
  logic               w_any_req;
  logic [3:0]         r_turn_cnt, w_turn_cnt_nxt;
  logic               w_release, w_preempt, w_turn_done;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_enable, w_enable_nxt;
  logic               r_rw, w_rw_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_preempt, w_preempt_nxt;

  // First requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_winner  = r_ptr;
    w_any_req = 1'b0;
    w_idx     = r_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = PtrW'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_any_req && io_bus.i_req[w_idx]) begin
        w_winner  = w_idx;
        w_any_req = 1'b1;
      end
    end
  end

  assign w_release   = (r_state == StGrant) && !io_bus.i_req[r_owner];
  assign w_turn_done = (32'(r_turn_cnt) + 32'd1) >= TURNAROUND;

`ifdef MBS_HOLD_LIMIT_EN
  logic [7:0] r_hold_cnt, w_hold_cnt_nxt;

  // Counter holds (grant cycles - 1); it saturates when nobody else is waiting.
  assign w_preempt = (r_state == StGrant) && !w_release &&
                     ((32'(r_hold_cnt) + 32'd1) >= MAX_GRANT) &&
                     (|(io_bus.i_req & ~r_grant));

  always_comb begin
    w_hold_cnt_nxt = r_hold_cnt;
    if (r_state != StGrant) begin
      w_hold_cnt_nxt = '0;
    end else if ((32'(r_hold_cnt) + 32'd1) < MAX_GRANT) begin
      w_hold_cnt_nxt = r_hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) r_hold_cnt <= '0;
    else             r_hold_cnt <= w_hold_cnt_nxt;
  end
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      r_state    <= StIdle;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_turn_cnt <= '0;
      r_grant    <= '0;
      r_enable   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_enable   <= w_enable_nxt;
      r_rw       <= w_rw_nxt;
      r_busy     <= w_busy_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_any_req) w_state_nxt = StGrant;
      StGrant: if (w_release || w_preempt) w_state_nxt = (TURNAROUND > 0) ? StTurn : StIdle;
      StTurn:  if (w_turn_done) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_grant_nxt    = r_grant;
    w_enable_nxt   = r_enable;
    w_rw_nxt       = r_rw;
    w_preempt_nxt  = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_turn_cnt_nxt = '0;
    case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_grant_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_enable_nxt = 1'b1;
          w_rw_nxt     = io_bus.i_rw[w_winner];
          w_owner_nxt  = w_winner;
          w_ptr_nxt    = (w_winner == PtrW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
      end
      StGrant: begin
        // Direction stays as latched at grant; only release or preemption ends ownership.
        if (w_release || w_preempt) begin
          w_grant_nxt   = '0;
          w_enable_nxt  = 1'b0;
          w_preempt_nxt = w_preempt;
        end
      end
      StTurn:  w_turn_cnt_nxt = r_turn_cnt + 4'd1;
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt != StIdle);
  end

  assign io_bus.o_grant           = r_grant;
  assign io_bus.o_data_bus_enable = r_enable;
  assign io_bus.o_data_bus_rw     = r_rw;
  assign io_bus.o_busy            = r_busy;
  assign io_bus.o_preempt         = r_preempt;
endmodule

// File: tb/tb_mem_bus_sched.sv
// Bench for mem_bus_sched: two instances (turnaround 3 and 0) checked every cycle against
// an ownership/timeline model, plus directed scenarios with literal expectations.
module tb_mem_bus_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned MG = 16;
`ifdef MBS_HOLD_LIMIT_EN
  localparam bit Limit = 1'b1;
`else
  localparam bit Limit = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [N-1:0] req_v [2];
  logic [N-1:0] rw_v  [2];
  logic [N-1:0] gnt_v [2];
  logic         en_v  [2];
  logic         drw_v [2];
  logic         busy_v[2];
  logic         pre_v [2];

  mem_bus_sched_if #(.NUM_REQ(N)) bus_a ();
  mem_bus_sched_if #(.NUM_REQ(N)) bus_b ();

  mem_bus_sched #(.NUM_REQ(N), .TURNAROUND(3), .MAX_GRANT(MG)) dut_a (
    .clk_166M66 (clk),
    .mcu_sys_rst(rst),
    .io_bus     (bus_a)
  );
  mem_bus_sched #(.NUM_REQ(N), .TURNAROUND(0), .MAX_GRANT(MG)) dut_b (
    .clk_166M66 (clk),
    .mcu_sys_rst(rst),
    .io_bus     (bus_b)
  );

  assign bus_a.i_req = req_v[0];
  assign bus_a.i_rw  = rw_v[0];
  assign bus_b.i_req = req_v[1];
  assign bus_b.i_rw  = rw_v[1];
  assign gnt_v[0] = bus_a.o_grant;
  assign gnt_v[1] = bus_b.o_grant;
  assign en_v[0] = bus_a.o_data_bus_enable;
  assign en_v[1] = bus_b.o_data_bus_enable;
  assign drw_v[0] = bus_a.o_data_bus_rw;
  assign drw_v[1] = bus_b.o_data_bus_rw;
  assign busy_v[0] = bus_a.o_busy;
  assign busy_v[1] = bus_b.o_busy;
  assign pre_v[0] = bus_a.o_preempt;
  assign pre_v[1] = bus_b.o_preempt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: current owner (-1 = none), next cycle arbitration may happen, rotating pointer.
  int   m_owner[2];
  int   m_ptr  [2];
  int   m_held [2];
  int   m_free [2];
  logic m_rw   [2];
  logic m_pre  [2];
  bit   m_live = 1'b0;

  function automatic int ta_of(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  function automatic void expect_eq(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void step(input int k, input logic [N-1:0] req, input logic [N-1:0] rw);
    logic [N-1:0] mine;
    m_pre[k] = 1'b0;
    if (rst) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_rw[k]    = 1'b0;
      m_free[k]  = 0;
      m_held[k]  = 0;
      return;
    end
    if (m_owner[k] >= 0) begin
      mine = '0;
      mine[m_owner[k]] = 1'b1;
      if (!req[m_owner[k]]) begin
        m_owner[k] = -1;
        m_free[k]  = cyc + ta_of(k) + 1;
      end else if (Limit && m_held[k] >= int'(MG) && (req & ~mine) != '0) begin
        m_pre[k]   = 1'b1;
        m_owner[k] = -1;
        m_free[k]  = cyc + ta_of(k) + 1;
      end else begin
        m_held[k]++;
      end
    end else if (cyc >= m_free[k] && req != '0) begin
      for (int i = 0; i < int'(N); i++) begin
        if (req[(m_ptr[k] + i) % N]) begin
          m_owner[k] = (m_ptr[k] + i) % N;
          break;
        end
      end
      m_rw[k]   = rw[m_owner[k]];
      m_ptr[k]  = (m_owner[k] + 1) % N;
      m_held[k] = 1;
    end
  endfunction

  function automatic void model_check(input int k);
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner[k] >= 0) eg[m_owner[k]] = 1'b1;
    expect_eq($sformatf("dut%0d grant", k), 32'(gnt_v[k]), 32'(eg));
    expect_eq($sformatf("dut%0d enable", k), 32'(en_v[k]), 32'(m_owner[k] >= 0));
    expect_eq($sformatf("dut%0d rw", k), 32'(drw_v[k]), 32'(m_rw[k]));
    expect_eq($sformatf("dut%0d busy", k), 32'(busy_v[k]),
              32'((m_owner[k] >= 0) || (cyc < m_free[k])));
    expect_eq($sformatf("dut%0d preempt", k), 32'(pre_v[k]), 32'(m_pre[k]));
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) step(k, req_v[k], rw_v[k]);
    if (rst) m_live = 1'b1;
    cyc++;
    @(negedge clk);
    if (m_live) for (int k = 0; k < 2; k++) model_check(k);
  endtask

  task automatic settle();
    int b;
    b = 60;
    req_v[0] = '0;
    req_v[1] = '0;
    do begin
      tick();
      b--;
    end while ((busy_v[0] || busy_v[1]) && b > 0);
    expect_eq("settle idle", {30'd0, busy_v[0], busy_v[1]}, 32'd0);
  endtask

  int ord_q[$];
  int gap_q[$];

  // All requesters in mask keep asking; each owner holds for 'hold' cycles, drops one cycle.
  task automatic run_rr(input int k, input logic [N-1:0] mask, input int hold, input int n);
    int held[N];
    bit drop[N];
    int gap;
    bit seen;
    bit prev_en;
    int budget;
    ord_q.delete();
    gap_q.delete();
    for (int r = 0; r < int'(N); r++) begin
      held[r] = 0;
      drop[r] = 1'b0;
    end
    req_v[k] = mask;
    gap = 0;
    seen = 1'b0;
    prev_en = 1'b0;
    budget = 400;
    while (ord_q.size() < n && budget > 0) begin
      tick();
      budget--;
      if (en_v[k] && !prev_en) begin
        for (int r = 0; r < int'(N); r++) if (gnt_v[k][r]) ord_q.push_back(r);
        if (seen) gap_q.push_back(gap);
        seen = 1'b1;
        gap = 0;
      end else if (!en_v[k] && seen) begin
        gap++;
      end
      prev_en = en_v[k];
      for (int r = 0; r < int'(N); r++) begin
        if (drop[r]) begin
          drop[r] = 1'b0;
          req_v[k][r] = 1'b1;
        end else if (gnt_v[k][r]) begin
          held[r]++;
          if (held[r] == hold) begin
            held[r] = 0;
            req_v[k][r] = 1'b0;
            drop[r] = 1'b1;
          end
        end
      end
    end
    expect_eq($sformatf("rr%0d grants", k), ord_q.size(), n);
    req_v[k] = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_rr[5];
    int exp_ab[4];
    int n0;
    int npre;
    int t;
    int since_pre;
    bit got2;
    exp_rr = '{0, 1, 2, 3, 0};
    exp_ab = '{0, 1, 0, 1};
    for (int k = 0; k < 2; k++) begin
      req_v[k] = '0;
      rw_v[k]  = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    expect_eq("reset grant", 32'(gnt_v[0]), 32'd0);
    expect_eq("reset enable", 32'(en_v[0]), 32'd0);
    expect_eq("reset busy", 32'(busy_v[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 2 with write direction.
    req_v[0] = 4'b0100;
    rw_v[0]  = 4'b0100;
    tick();
    expect_eq("t1 grant", 32'(gnt_v[0]), 32'h4);
    expect_eq("t1 enable", 32'(en_v[0]), 32'd1);
    expect_eq("t1 rw", 32'(drw_v[0]), 32'd1);
    expect_eq("t1 busy", 32'(busy_v[0]), 32'd1);
    settle();
    rw_v[0] = '0;

    // Round robin from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_rr(0, 4'b1111, 4, 5);
    for (int i = 0; i < 5; i++)
      expect_eq($sformatf("rr order %0d", i), (i < ord_q.size()) ? ord_q[i] : -1, exp_rr[i]);
    expect_eq("rr gap count", gap_q.size(), 4);
    for (int i = 0; i < gap_q.size(); i++)
      expect_eq($sformatf("rr gap %0d", i), gap_q[i], 4);
    settle();

    // Direction is latched at grant.
    req_v[0] = 4'b0010;
    rw_v[0]  = 4'b0000;
    tick();
    expect_eq("t3 grant", 32'(gnt_v[0]), 32'h2);
    rw_v[0][1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_eq("t3 rw held", 32'(drw_v[0]), 32'd0);
    end
    req_v[0] = '0;
    tick();
    expect_eq("t3 release grant", 32'(gnt_v[0]), 32'd0);
    expect_eq("t3 release rw", 32'(drw_v[0]), 32'd0);
    settle();

    // Reset in the middle of requester 3's grant.
    req_v[0] = 4'b1000;
    rw_v[0]  = 4'b1000;
    tick();
    expect_eq("t4 grant", 32'(gnt_v[0]), 32'h8);
    expect_eq("t4 rw", 32'(drw_v[0]), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    expect_eq("t4 rst grant", 32'(gnt_v[0]), 32'd0);
    expect_eq("t4 rst enable", 32'(en_v[0]), 32'd0);
    expect_eq("t4 rst rw", 32'(drw_v[0]), 32'd0);
    expect_eq("t4 rst busy", 32'(busy_v[0]), 32'd0);
    rst = 1'b0;
    req_v[0] = 4'b1111;
    tick();
    expect_eq("t4 after rst grant", 32'(gnt_v[0]), 32'h1);
    settle();
    rw_v[0] = '0;

    // Zero turnaround: alternate requesters 0 and 1.
    run_rr(1, 4'b0011, 3, 4);
    for (int i = 0; i < 4; i++)
      expect_eq($sformatf("ta0 order %0d", i), (i < ord_q.size()) ? ord_q[i] : -1, exp_ab[i]);
    expect_eq("ta0 gap count", gap_q.size(), 3);
    for (int i = 0; i < gap_q.size(); i++)
      expect_eq($sformatf("ta0 gap %0d", i), gap_q[i], 1);
    settle();

    // Long hold by requester 0 while requester 2 waits.
    req_v[0] = 4'b0001;
    tick();
    expect_eq("hold grant", 32'(gnt_v[0]), 32'h1);
    req_v[0] = 4'b0101;
    n0 = 1;
    npre = 0;
    t = 0;
    since_pre = -1;
    got2 = 1'b0;
    while (!got2 && t < 40) begin
      tick();
      t++;
      if (gnt_v[0] == 4'b0001) n0++;
      if (since_pre >= 0) since_pre++;
      if (pre_v[0]) begin
        npre++;
        since_pre = 0;
      end
      if (gnt_v[0] == 4'b0100) got2 = 1'b1;
    end
`ifdef MBS_HOLD_LIMIT_EN
    expect_eq("hold owner cycles", n0, 16);
    expect_eq("hold preempt pulses", npre, 1);
    expect_eq("hold handover", got2, 1);
    expect_eq("hold preempt to grant", since_pre, 4);
`else
    expect_eq("hold owner cycles", n0, 41);
    expect_eq("hold preempt pulses", npre, 0);
    expect_eq("hold handover", got2, 0);
`endif
    settle();

    // Lone requester is never preempted.
    req_v[0] = 4'b0001;
    n0 = 0;
    npre = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt_v[0] == 4'b0001) n0++;
      if (pre_v[0]) npre++;
    end
    expect_eq("alone owner cycles", n0, 40);
    expect_eq("alone preempt pulses", npre, 0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
